sum_vector_arb: RTL and testbench

Round-robin scheduler that shares one `sum_vector` reduction unit (HALF or SINGLE) among `REQ` requesters. Accepts vector operands with a valid/ready handshake and issues at most one vector per cycle to the shared unit. It records the requester ID of every issued vector in an in-order tag FIFO and routes each returned sum to its originating requester. Sits between compute clients, such as dot-product or norm engines, and the single shared adder tree.

---
 rtl/sum_vector_arb_if.sv | 31 +++
 rtl/sum_vector_arb.sv | 123 ++++++++++++
 tb/tb_sum_vector_arb.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_vector_arb_if.sv
// Bus bundle between sum_vector_arb and its environment: requester side, shared-unit side,
// response side and the outstanding count. The arbiter uses the slave modport.
interface sum_vector_arb_if #(
  parameter int BITS      = 16,
  parameter int N         = 3,
  parameter int REQ       = 4,
  parameter int TAG_DEPTH = 8
);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic [REQ-1:0]        req_valid;
  logic [REQ*N*BITS-1:0] req_vin;
  logic [REQ-1:0]        req_ready;
  logic                  sum_in_valid;
  logic [N*BITS-1:0]     sum_vin;
  logic                  sum_out_valid;
  logic [BITS-1:0]       sum_result;
  logic [REQ-1:0]        rsp_valid;
  logic [BITS-1:0]       rsp_sum;
  logic [CW-1:0]         outstanding;

  modport master (
    output req_valid, req_vin, sum_out_valid, sum_result,
    input  req_ready, sum_in_valid, sum_vin, rsp_valid, rsp_sum, outstanding
  );

  modport slave (
    input  req_valid, req_vin, sum_out_valid, sum_result,
    output req_ready, sum_in_valid, sum_vin, rsp_valid, rsp_sum, outstanding
  );
endinterface

// File: rtl/sum_vector_arb.sv
// Round-robin front end sharing one in-order sum_vector unit among REQ requesters; an in-order
// tag FIFO routes each returned sum back. Define SUM_VECTOR_ARB_ERR_EN for a sticky err_underflow.
module sum_vector_arb #(
  parameter int BITS      = 16,
  parameter int N         = 3,
  parameter int REQ       = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic clk,
  input  logic rstn,
`ifdef SUM_VECTOR_ARB_ERR_EN
  output logic err_underflow,
`endif
  sum_vector_arb_if.slave bus
);
  localparam int IW = $clog2(REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = N * BITS;

  logic [VW-1:0]   field [REQ];
  logic [REQ-1:0]  grant;
  logic [IW-1:0]   grant_id;
  logic [IW-1:0]   last_grant_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [IW-1:0]   tag_mem [TAG_DEPTH];
  logic [IW-1:0]   head_tag;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            sum_in_valid_reg;
  logic [VW-1:0]   sum_vin_reg;
  logic [REQ-1:0]  rsp_valid_reg;
  logic [BITS-1:0] rsp_sum_reg;

  generate
    for (genvar gi = 0; gi < REQ; gi++) begin : g_field
      assign field[gi] = bus.req_vin[gi*VW +: VW];
    end
  endgenerate

  // Walk from farthest to nearest so the first valid requester after last_grant wins.
  always_comb begin
    int pos;
    int id;
    pos      = 0;
    id       = 0;
    grant    = '0;
    grant_id = '0;
    for (int k = REQ; k >= 1; k--) begin
      pos = int'(last_grant_reg) + k;
      id  = (pos >= REQ) ? pos - REQ : pos;
      if (bus.req_valid[id]) begin
        grant     = '0;
        grant[id] = 1'b1;
        grant_id  = IW'(id);
      end
    end
  end

  // A same-cycle pop never frees a slot for issue: full looks only at the registered count.
  assign full          = (outstanding_reg == CW'(TAG_DEPTH));
  assign empty         = (outstanding_reg == '0);
  assign bus.req_ready = full ? '0 : grant;
  assign push          = |bus.req_ready;
  assign pop           = bus.sum_out_valid & ~empty;
  assign head_tag      = tag_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_reg   <= IW'(REQ - 1);
      outstanding_reg  <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      sum_in_valid_reg <= 1'b0;
      sum_vin_reg      <= '0;
      rsp_valid_reg    <= '0;
      rsp_sum_reg      <= '0;
    end else begin
      sum_in_valid_reg <= push;
      if (push) begin
        sum_vin_reg    <= field[grant_id];
        last_grant_reg <= grant_id;
        wr_ptr_reg     <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        rsp_sum_reg <= bus.sum_result;
      end
      rsp_valid_reg <= pop ? (REQ'(1) << head_tag) : '0;
      case ({push, pop})
        2'b10:   outstanding_reg <= outstanding_reg + CW'(1);
        2'b01:   outstanding_reg <= outstanding_reg - CW'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

`ifdef SUM_VECTOR_ARB_ERR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_underflow <= 1'b0;
    end else if (bus.sum_out_valid && empty) begin
      err_underflow <= 1'b1;
    end
  end
`endif

  assign bus.sum_in_valid = sum_in_valid_reg;
  assign bus.sum_vin      = sum_vin_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_sum      = rsp_sum_reg;
  assign bus.outstanding  = outstanding_reg;
endmodule

// File: tb/tb_sum_vector_arb.sv
// Randomized bench for sum_vector_arb: a queue-based model of the shared HALF adder and a
// reference scheduler (round-robin list walk, tag queue, outstanding count) check every cycle.
module tb_sum_vector_arb;
  localparam int BITS      = 16;
  localparam int N         = 3;
  localparam int REQ       = 4;
  localparam int TAG_DEPTH = 8;
  localparam int UNIT_LAT  = 2;
  localparam int VW        = N * BITS;

  typedef struct {int id; logic [15:0] sum;} tag_t;
  typedef struct {int due; logic [15:0] res;} unit_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  sum_vector_arb_if #(.BITS(BITS), .N(N), .REQ(REQ), .TAG_DEPTH(TAG_DEPTH)) bus ();

`ifdef SUM_VECTOR_ARB_ERR_EN
  logic err_underflow;
`endif

  sum_vector_arb #(.BITS(BITS), .N(N), .REQ(REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
`ifdef SUM_VECTOR_ARB_ERR_EN
    .err_underflow (err_underflow),
`endif
    .bus           (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    edge_n   = 0;
  int    out_cnt  = 0;
  int    last_g   = REQ - 1;
  bit    hold     = 1'b0;
  bit    exp_err  = 1'b0;
  tag_t  tag_q[$];
  unit_t unit_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [15:0] int2half(input int v);
    int e;
    if (v == 0) return 16'h0000;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return {1'b0, 5'(e + 15), 10'((v - (1 << e)) << (10 - e))};
  endfunction

  function automatic int half2int(input logic [15:0] h);
    int e;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]) - 15;
    return (1024 + int'(h[9:0])) >> (10 - e);
  endfunction

  function automatic logic [15:0] half_sum(input logic [VW-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += half2int(v[k*BITS +: BITS]);
    return int2half(s);
  endfunction

  function automatic logic [REQ*VW-1:0] rand_vin();
    logic [REQ*VW-1:0] r;
    r = '0;
    for (int j = 0; j < REQ * N; j++) r[j*BITS +: BITS] = int2half($urandom_range(0, 255));
    return r;
  endfunction

  // Reference arbiter: requesters after the last winner first, then wrap to the front.
  function automatic int model_grant(input logic [REQ-1:0] v);
    if (out_cnt == TAG_DEPTH) return -1;
    for (int i = last_g + 1; i < REQ; i++) if (v[i]) return i;
    for (int i = 0; i <= last_g; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: drive at posedge+1, check grant at negedge, check registered outputs at posedge+1.
  task automatic tick(input logic [REQ-1:0] v, input logic [REQ*VW-1:0] vin);
    int              g;
    bit              pres;
    logic [VW-1:0]   win_vin;
    logic [REQ-1:0]  exp_rv;
    logic [15:0]     exp_rs;
    tag_t            t;
    bus.req_valid     = v;
    bus.req_vin       = vin;
    pres              = !hold && unit_q.size() > 0 && unit_q[0].due <= edge_n + 1;
    bus.sum_out_valid = pres;
    bus.sum_result    = pres ? unit_q[0].res : 16'($urandom);
    g                 = model_grant(v);
    win_vin           = (g >= 0) ? vin[g*VW +: VW] : '0;
    @(negedge clk);
    check("req_ready", bus.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    edge_n++;
    exp_rv = '0;
    exp_rs = 'x;
    if (pres) begin
      unit_q.delete(0);
      if (tag_q.size() > 0) begin
        t      = tag_q.pop_front();
        exp_rv = REQ'(1) << t.id;
        exp_rs = t.sum;
        out_cnt--;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (g >= 0) begin
      tag_q.push_back('{g, half_sum(win_vin)});
      out_cnt++;
      last_g = g;
    end
    #1;
    check("sum_in_valid", bus.sum_in_valid, (g >= 0));
    if (g >= 0) check("sum_vin", bus.sum_vin, win_vin);
    if (bus.sum_in_valid) unit_q.push_back('{edge_n + 1 + UNIT_LAT, half_sum(bus.sum_vin)});
    check("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_rv != '0) check("rsp_sum", bus.rsp_sum, exp_rs);
    check("outstanding", bus.outstanding, out_cnt);
`ifdef SUM_VECTOR_ARB_ERR_EN
    check("err_underflow", err_underflow, exp_err);
`endif
  endtask

  // Results still inside the shared unit model survive reset and come back as stray returns.
  task automatic do_reset();
    rstn              = 1'b0;
    bus.req_valid     = 4'b0001;
    bus.req_vin       = rand_vin();
    bus.sum_out_valid = 1'b0;
    tag_q.delete();
    out_cnt = 0;
    last_g  = REQ - 1;
    exp_err = 1'b0;
    #1;
    check("rst_sum_in_valid", bus.sum_in_valid, 0);
    check("rst_sum_vin", bus.sum_vin, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_sum", bus.rsp_sum, 0);
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_req_ready", bus.req_ready, 4'b0001);
`ifdef SUM_VECTOR_ARB_ERR_EN
    check("rst_err_underflow", err_underflow, 0);
`endif
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    bus.req_valid = '0;
    rstn          = 1'b1;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic drain();
    int n;
    n    = 0;
    hold = 1'b0;
    while ((unit_q.size() != 0 || tag_q.size() != 0) && n < 200) begin
      tick('0, rand_vin());
      n++;
    end
    check("drain", unit_q.size() + tag_q.size(), 0);
  endtask

  initial begin
    logic [REQ*VW-1:0] vin;
    bus.req_valid     = '0;
    bus.req_vin       = '0;
    bus.sum_out_valid = 1'b0;
    bus.sum_result    = '0;
    #1;
    do_reset();

    // single request: 1+2+3 in HALF
    vin = rand_vin();
    vin[0 +: VW] = {16'h4200, 16'h4000, 16'h3C00};
    tick(4'b0001, vin);
    drain();

    // fairness with all four requesting
    repeat (8) tick(4'b1111, rand_vin());
    drain();

    // full stall, then release the shared unit
    hold = 1'b1;
    repeat (11) tick(4'b1111, rand_vin());
    hold = 1'b0;
    repeat (4) tick(4'b1111, rand_vin());
    drain();

    // simultaneous push and pop at three outstanding
    hold = 1'b1;
    repeat (3) tick(4'b0001, rand_vin());
    repeat (3) tick('0, rand_vin());
    hold = 1'b0;
    tick(4'b0010, rand_vin());
    tick(4'b0100, rand_vin());
    drain();

    // sparse requesters
    repeat (6) tick(4'b1010, rand_vin());
    drain();

    // random traffic with random back-pressure from the shared unit
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) hold = ~hold;
      tick(REQ'($urandom_range(0, 15)), rand_vin());
    end
    drain();

    // reset with three vectors in flight; their returns surface afterwards
    hold = 1'b1;
    repeat (3) tick(4'b0111, rand_vin());
    do_reset();
    hold = 1'b0;
    drain();
    repeat (4) tick(4'b1001, rand_vin());
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
